// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register file write port between writeback and a buffered MD result FIFO.
// It also tracks pending MD destinations for the decode stall. Optional macro STARVE_GUARD_EN forces a FIFO drain after STARVE_LIMIT blocked cycles.
`default_nettype none

module regfile_write_scheduler #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        wbRegWrite,
   input  logic [4:0]  wbWriteRegister,
   input  logic [31:0] wbWriteData,
   input  logic        mdIssue,
   input  logic [4:0]  mdIssueRegister,
   input  logic        mdValid,
   input  logic [4:0]  mdWriteRegister,
   input  logic [31:0] mdWriteData,
   output logic        mdReady,
   input  logic [4:0]  idRs,
   input  logic [4:0]  idRt,
   input  logic [4:0]  idDest,
   output logic        stallId,
   output logic        regWrite,
   output logic [4:0]  writeRegister,
   output logic [31:0] writeData,
   output logic        writeSource,
   output logic [2:0]  fifoCount,
   output logic [31:0] pendingMask,
   output logic        pipeStall
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [4:0]       reg_mem  [FIFO_DEPTH];
   logic [31:0]      data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [4:0]       last_reg;
   logic [31:0]      last_data;
   logic [31:0]      next_mask;

   logic empty, full, push, wb_win, fifo_grant, fifo_write, wb_write, force_drain;

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign push       = mdValid && !full;
   assign wb_win     = wbRegWrite && (wbWriteRegister != 5'd0);
   assign fifo_grant = !empty && (!wb_win || force_drain);
   assign fifo_write = fifo_grant && (reg_mem[rd_ptr] != 5'd0);
   assign wb_write   = wb_win && !fifo_grant;

   assign mdReady   = !full;
   assign fifoCount = 3'(count);
   assign pipeStall = force_drain;

`ifdef STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   logic [SC_W-1:0] starve_cnt;

   // Reaching the limit at the edge makes the following cycle the forced-drain cycle.
   assign force_drain = (starve_cnt == SC_W'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         starve_cnt <= '0;
      else if (fifo_grant)
         starve_cnt <= '0;
      else if (!empty)
         starve_cnt <= starve_cnt + SC_W'(1);
   end
`else
   assign force_drain = 1'b0;
`endif

   always_comb begin
      regWrite      = wb_write | fifo_write;
      writeSource   = fifo_grant;
      writeRegister = last_reg;
      writeData     = last_data;
      if (fifo_write) begin
         writeRegister = reg_mem[rd_ptr];
         writeData     = data_mem[rd_ptr];
      end else if (wb_write) begin
         writeRegister = wbWriteRegister;
         writeData     = wbWriteData;
      end
   end

   // Set is applied after clear so a re-issue to the draining register stays pending.
   always_comb begin
      next_mask = pendingMask;
      if (fifo_write)
         next_mask[reg_mem[rd_ptr]] = 1'b0;
      if (mdIssue && (mdIssueRegister != 5'd0))
         next_mask[mdIssueRegister] = 1'b1;
   end

   assign stallId = ((idRs   != 5'd0) && pendingMask[idRs])
                  | ((idRt   != 5'd0) && pendingMask[idRt])
                  | ((idDest != 5'd0) && pendingMask[idDest]);

   always_ff @(posedge clk) begin
      if (push) begin
         reg_mem[wr_ptr]  <= mdWriteRegister;
         data_mem[wr_ptr] <= mdWriteData;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         pendingMask <= '0;
         last_reg    <= '0;
         last_data   <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_grant)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !fifo_grant)
            count <= count + CNT_W'(1);
         else if (!push && fifo_grant)
            count <= count - CNT_W'(1);
         pendingMask <= next_mask;
         if (regWrite) begin
            last_reg  <= writeRegister;
            last_data <= writeData;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the register file's single write port between two requesters: the writeback stage and a long-latency multiply/divide unit.
- Buffers long-latency results in a small FIFO.
- Keeps a pending-destination scoreboard that stalls instruction decode on RAW/WAW hazards against outstanding long-latency results.
- Sits between the writeback stage, the MD unit and the decode stage's register file write inputs.

Parameters:
FIFO_DEPTH, 4, MD result buffer entries; power of two, >=2
STARVE_LIMIT, 8, consecutive blocked cycles before a forced drain (optional feature only)

Ports:
clk  in  1  clock; all state updates on rising edge
resetN  in  1  asynchronous active-low reset
wbRegWrite  in  1  writeback stage write request
wbWriteRegister  in  5  writeback destination
wbWriteData  in  32  writeback data
mdIssue  in  1  decode issued a long-latency op this cycle
mdIssueRegister  in  5  destination of issued long-latency op
mdValid  in  1  MD unit result valid
mdWriteRegister  in  5  MD result destination
mdWriteData  in  32  MD result data
mdReady  out  1  FIFO can accept; equals !full
idRs, idRt, idDest  in  5 each  register fields of the instruction in decode
stallId  out  1  decode must hold; combinational
regWrite  out  1  register file write enable
writeRegister  out  5  register file write address
writeData  out  32  register file write data
writeSource  out  1  0 = writeback, 1 = FIFO head
fifoCount  out  3  FIFO occupancy, 0..FIFO_DEPTH
pendingMask  out  32  registered scoreboard
pipeStall  out  1  forced-drain freeze request; tied 0 without feature

Behaviour:
- Reset (async, resetN=0): FIFO empty, fifoCount=0, pendingMask=0, regWrite=0, writeSource=0, mdReady=1, stallId=0, pipeStall=0, starvation counter=0.
- Push:
  - mdValid && mdReady pushes {reg,data} at the edge.
  - mdValid while full is ignored; the entry is lost and it is the MD unit's duty to hold the result.
  - No write-through bypass: minimum latency mdValid to regWrite is 1 cycle.
- Grant (combinational each cycle):
  - Writeback wins when wbRegWrite=1 and wbWriteRegister!=0: regWrite=1, writeSource=0, outputs carry the wb fields.
  - Otherwise, if the FIFO is non-empty: regWrite=1, writeSource=1, outputs carry the FIFO head; the head pops at the edge.
  - Otherwise regWrite=0; writeRegister and writeData hold their last values.
- Register 0:
  - A writeback write to r0 is suppressed and does not block the FIFO; the FIFO may drain that cycle.
  - A FIFO head with reg 0 pops with regWrite=0.
- Simultaneous push and pop: both occur; count unchanged. Full with a pop this cycle still shows mdReady=0.
- Scoreboard:
  - mdIssue with mdIssueRegister!=0 sets pendingMask[reg] at the edge.
  - A FIFO-sourced write to reg clears that bit at the same edge.
  - Simultaneous set and clear of the same bit: set wins.
- stallId = pendingMask[idRs] | pendingMask[idRt] | pendingMask[idDest], with index 0 excluded. It uses the registered mask, so it stays 1 through the write cycle and drops the cycle after.
- Ordering: stallId prevents a new writer to a pending register, so WB/FIFO writes to the same register cannot reorder.
- Reset mid-operation: FIFO contents and scoreboard discarded immediately; the pipeline is reset alongside.

Optional Feature:
STARVE_GUARD_EN:
- Defined:
  - An internal counter increments each cycle the FIFO is non-empty and not granted, and clears on any FIFO grant.
  - When the counter reaches STARVE_LIMIT, pipeStall=1 for exactly the next cycle.
  - In that cycle the FIFO head is granted regardless of wbRegWrite. The pipeline is frozen and re-presents its writeback the following cycle.
  - Counter clears.
- Undefined: no counter logic; pipeStall tied to 0; writeback always has priority, and the FIFO can starve indefinitely.

Test Plan:
- Reset -> regWrite=0, fifoCount=0, pendingMask=0, mdReady=1; assert resetN low mid-transfer with fifoCount=2 -> fifoCount=0 and pendingMask=0 without waiting for a clock.
- mdIssue r5, then idRs=5 -> stallId=1; mdValid r5=0xDEADBEEF with writeback idle -> next cycle regWrite=1, writeRegister=5, writeData=0xDEADBEEF, writeSource=1; the cycle after, pendingMask[5]=0 and stallId=0.
- FIFO holds r7 while wbRegWrite r3 is held for 3 cycles -> 3 writeback writes with writeSource=0, then r7 written in cycle 4.
- Writeback busy, 4 mdValid pushes -> fifoCount=4, mdReady=0; 5th push ignored; drain yields exactly the 4 entries in order.
- wbRegWrite to r0 with FIFO head r9 -> regWrite=1, writeRegister=9, writeSource=1 that cycle.
- With STARVE_GUARD_EN, STARVE_LIMIT=8, writeback continuously busy and FIFO non-empty -> pipeStall=1 in cycle 9 with writeSource=1; without the macro, pipeStall stays 0 and the FIFO never drains.
